// File: rtl/integral_image_builder_if.sv
// Pixel-stream input and integral-cache write port of the integral image builder.
// The builder is the slave; the pixel source / cache side is the master.
interface integral_image_builder_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned SUM_W = 20,
    parameter int unsigned X_W   = 6,
    parameter int unsigned Y_W   = 5
) ();
    logic             start;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic             ii_we;
    logic [X_W-1:0]   ii_waddrX;
    logic [Y_W-1:0]   ii_waddrY;
    logic [SUM_W-1:0] ii_wdata;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, pix_valid, pix_data,
        input  pix_ready, ii_we, ii_waddrX, ii_waddrY, ii_wdata, busy, frame_done
    );

    modport slave (
        input  start, pix_valid, pix_data,
        output pix_ready, ii_we, ii_waddrX, ii_waddrY, ii_wdata, busy, frame_done
    );
endinterface

// File: rtl/integral_image_builder.sv
// Streaming integral image builder: consumes pixels in raster order and writes
// ii(x,y) = sum of all pixels above and left (inclusive) one cycle after each
// accepted pixel. One row of previous integral values is kept in a line buffer.
module integral_image_builder #(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 24,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned SUM_W = 20,
    parameter int unsigned X_W   = 6,
    parameter int unsigned Y_W   = 5
) (
    input logic                      clk,
    input logic                      rst_n,
    integral_image_builder_if.slave  bus
);

    localparam int unsigned BUF_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

    state_e           r_state;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [SUM_W-1:0] r_rowsum;
    logic             r_pix_ready;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_we;
    logic [X_W-1:0]   r_waddr_x;
    logic [Y_W-1:0]   r_waddr_y;
    logic [SUM_W-1:0] r_wdata;

    // Previous row's integral values; never cleared, row 0 masks it instead.
    logic [SUM_W-1:0] r_prev [IMG_W];

    logic              w_accept;
    logic              w_x_last;
    logic              w_y_last;
    logic [BUF_AW-1:0] w_buf_idx;
    logic [SUM_W-1:0]  w_pix_ext;
    logic [SUM_W-1:0]  w_above;
    logic [SUM_W-1:0]  w_rowsum_new;
    logic [SUM_W-1:0]  w_ii;

    // Acceptance and the integral arithmetic for the pixel at (r_x, r_y).
    always_comb begin
        w_accept     = bus.pix_valid & r_pix_ready;
        w_x_last     = (r_x == X_W'(IMG_W - 1));
        w_y_last     = (r_y == Y_W'(IMG_H - 1));
        w_buf_idx    = r_x[BUF_AW-1:0];
        w_pix_ext    = SUM_W'(bus.pix_data);
        w_above      = (r_y == '0) ? '0 : r_prev[w_buf_idx];
        w_rowsum_new = (r_x == '0) ? w_pix_ext : r_rowsum + w_pix_ext;
        w_ii         = w_rowsum_new + w_above;
    end

    // Control FSM, raster counters, row accumulator and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_x          <= '0;
            r_y          <= '0;
            r_rowsum     <= '0;
            r_pix_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_we         <= 1'b0;
            r_waddr_x    <= '0;
            r_waddr_y    <= '0;
            r_wdata      <= '0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_we      <= 1'b1;
                r_waddr_x <= r_x;
                r_waddr_y <= r_y;
                r_wdata   <= w_ii;
                r_rowsum  <= w_rowsum_new;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state     <= StActive;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                StActive: begin
                    if (w_accept && w_x_last && w_y_last) begin
                        r_state     <= StFlush;
                        r_pix_ready <= 1'b0;
                    end
                end
                StFlush: begin
                    // Last write is on the port this cycle; done follows it.
                    r_state      <= StIdle;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                end
                default: begin
                    r_state     <= StIdle;
                    r_pix_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer update: read-before-write of the same column in one cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_prev[w_buf_idx] <= w_ii;
        end
    end

    assign bus.pix_ready  = r_pix_ready;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.ii_we      = r_we;
    assign bus.ii_waddrX  = r_waddr_x;
    assign bus.ii_waddrY  = r_waddr_y;
    assign bus.ii_wdata   = r_wdata;

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for integral_image_builder: a 4x3 instance driven from a table
// of hand-computed integral values, plus a default-size instance for the
// all-255 full-frame sum.
module tb_integral_image_builder;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned SW = 12;
    localparam int unsigned NP = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    integral_image_builder_if #(.PIX_W(8), .SUM_W(SW), .X_W(2), .Y_W(2)) sm_if ();
    integral_image_builder_if big_if ();

    integral_image_builder #(
        .IMG_W(W), .IMG_H(H), .PIX_W(8), .SUM_W(SW), .X_W(2), .Y_W(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sm_if.slave)
    );

    integral_image_builder dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (big_if.slave)
    );

    typedef struct {
        int x;
        int y;
        int pix_ramp;
        int ii_ones;
        int ii_ramp;
    } vec_t;

    vec_t vecs[NP];

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int cap_x[$];
    int cap_y[$];
    int cap_d[$];
    int cap_c[$];
    int n_done   = 0;
    int done_cyc = 0;
    bit chk_we   = 1'b0;
    bit acc_prev = 1'b0;

    int big_n    = 0;
    int big_last = 0;
    int big_lx   = 0;
    int big_ly   = 0;
    int big_done = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done capture and per-cycle check that ii_we follows acceptance.
    always @(negedge clk) begin
        if (sm_if.ii_we) begin
            cap_x.push_back(int'(sm_if.ii_waddrX));
            cap_y.push_back(int'(sm_if.ii_waddrY));
            cap_d.push_back(int'(sm_if.ii_wdata));
            cap_c.push_back(cyc);
        end
        if (sm_if.frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (chk_we) chk("ii_we_follows_accept", longint'(sm_if.ii_we), longint'(acc_prev));
        acc_prev = sm_if.pix_valid && sm_if.pix_ready;
        if (big_if.ii_we) begin
            big_n++;
            big_last = int'(big_if.ii_wdata);
            big_lx   = int'(big_if.ii_waddrX);
            big_ly   = int'(big_if.ii_waddrY);
        end
        if (big_if.frame_done) big_done++;
    end

    task automatic clear_cap();
        cap_x.delete();
        cap_y.delete();
        cap_d.delete();
        cap_c.delete();
        n_done = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_pix_ready"},  longint'(sm_if.pix_ready),  0);
        chk({tag, "_ii_we"},      longint'(sm_if.ii_we),      0);
        chk({tag, "_waddrX"},     longint'(sm_if.ii_waddrX),  0);
        chk({tag, "_waddrY"},     longint'(sm_if.ii_waddrY),  0);
        chk({tag, "_wdata"},      longint'(sm_if.ii_wdata),   0);
        chk({tag, "_busy"},       longint'(sm_if.busy),       0);
        chk({tag, "_frame_done"}, longint'(sm_if.frame_done), 0);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_start();
        sm_if.start = 1'b1;
        @(posedge clk);
        #1 sm_if.start = 1'b0;
        chk("ready_in_active", longint'(sm_if.pix_ready), 1);
        chk("busy_in_active",  longint'(sm_if.busy),      1);
    endtask

    // mode 0: all ones, mode 1: ramp x+4y.
    task automatic feed(input int mode, input bit gap, input bit mid_start, input int npix);
        for (int i = 0; i < npix; i++) begin
            sm_if.pix_valid = 1'b1;
            sm_if.pix_data  = (mode == 1) ? 8'(vecs[i].pix_ramp) : 8'd1;
            if (mid_start && i == 3) sm_if.start = 1'b1;
            @(posedge clk);
            #1;
            sm_if.start = 1'b0;
            if (gap && i != npix - 1) begin
                sm_if.pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        sm_if.pix_valid = 1'b0;
        if (npix == NP) begin
            chk("ready_in_flush", longint'(sm_if.pix_ready), 0);
            chk("busy_in_flush",  longint'(sm_if.busy),      1);
        end
    endtask

    task automatic wait_done(input bit start_next);
        bit seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (sm_if.frame_done) begin
                seen = 1'b1;
                chk("busy_low_on_done", longint'(sm_if.busy), 0);
                if (start_next) sm_if.start = 1'b1;
            end
        end
        chk("frame_done_seen", longint'(seen), 1);
        @(posedge clk);
        #1 sm_if.start = 1'b0;
    endtask

    task automatic check_frame(input int mode, input string tag);
        chk({tag, "_nwrites"}, cap_x.size(), NP);
        chk({tag, "_ndone"},   n_done,       1);
        for (int i = 0; i < NP && i < cap_x.size(); i++) begin
            chk($sformatf("%s_x[%0d]", tag, i), cap_x[i], vecs[i].x);
            chk($sformatf("%s_y[%0d]", tag, i), cap_y[i], vecs[i].y);
            chk($sformatf("%s_ii[%0d]", tag, i), cap_d[i],
                (mode == 1) ? vecs[i].ii_ramp : vecs[i].ii_ones);
        end
        if (cap_c.size() == NP) chk({tag, "_done_latency"}, done_cyc, cap_c[NP-1] + 1);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0,  1, 0};
        vecs[1]  = '{1, 0, 1,  2, 1};
        vecs[2]  = '{2, 0, 2,  3, 3};
        vecs[3]  = '{3, 0, 3,  4, 6};
        vecs[4]  = '{0, 1, 4,  2, 4};
        vecs[5]  = '{1, 1, 5,  4, 10};
        vecs[6]  = '{2, 1, 6,  6, 18};
        vecs[7]  = '{3, 1, 7,  8, 28};
        vecs[8]  = '{0, 2, 8,  3, 12};
        vecs[9]  = '{1, 2, 9,  6, 27};
        vecs[10] = '{2, 2, 10, 9, 45};
        vecs[11] = '{3, 2, 11, 12, 66};

        sm_if.start      = 1'b0;
        sm_if.pix_valid  = 1'b0;
        sm_if.pix_data   = '0;
        big_if.start     = 1'b0;
        big_if.pix_valid = 1'b0;
        big_if.pix_data  = '0;

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_we = 1'b1;

        // All ones, valid held high.
        clear_cap();
        do_start();
        feed(0, 1'b0, 1'b0, NP);
        wait_done(1'b0);
        check_frame(0, "ones");

        // Same frame with valid toggling.
        clear_cap();
        do_start();
        feed(0, 1'b1, 1'b0, NP);
        wait_done(1'b0);
        check_frame(0, "ones_gap");

        // Ramp image.
        clear_cap();
        do_start();
        feed(1, 1'b0, 1'b0, NP);
        wait_done(1'b0);
        check_frame(1, "ramp");

        // Reset after 5 pixels abandons the frame.
        clear_cap();
        do_start();
        feed(0, 1'b0, 1'b0, 5);
        chk_we = 1'b0;
        chk("pre_reset_we", longint'(sm_if.ii_we), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_nwrites", cap_x.size(), 4);
        chk("midreset_ndone",   n_done,       0);
        chk("midreset_busy",    longint'(sm_if.busy), 0);
        chk_we = 1'b1;
        clear_cap();
        do_start();
        feed(0, 1'b0, 1'b0, NP);
        wait_done(1'b0);
        check_frame(0, "after_reset");

        // Start during ACTIVE ignored; start on frame_done begins next frame.
        clear_cap();
        do_start();
        feed(1, 1'b0, 1'b1, NP);
        wait_done(1'b1);
        check_frame(1, "mid_start");
        clear_cap();
        chk("restart_ready", longint'(sm_if.pix_ready), 1);
        feed(0, 1'b0, 1'b0, NP);
        wait_done(1'b0);
        check_frame(0, "back_to_back");
        chk_we = 1'b0;

        // Default-size frame of 255s.
        big_if.start = 1'b1;
        @(posedge clk);
        #1 big_if.start = 1'b0;
        big_if.pix_valid = 1'b1;
        big_if.pix_data  = 8'd255;
        repeat (32 * 24) @(posedge clk);
        #1 big_if.pix_valid = 1'b0;
        for (int k = 0; k < 20 && big_done == 0; k++) @(posedge clk);
        #1;
        chk("big_nwrites", big_n,    768);
        chk("big_last_ii", big_last, 195840);
        chk("big_last_x",  big_lx,   31);
        chk("big_last_y",  big_ly,   23);
        chk("big_ndone",   big_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/integral_image_builder.md
INTEGRAL_IMAGE_BUILDER -- requirements
Module: integral_image_builder

Interface
REQ-001 Parameter IMG_W, default 32, pixels per row.
REQ-002 Parameter IMG_H, default 24, rows per frame.
REQ-003 Parameter PIX_W, default 8, input pixel width.
REQ-004 Parameter SUM_W, default 20, integral value width; SHALL be at least ceil(log2(IMG_W*IMG_H*(2^PIX_W-1)+1)).
REQ-005 Parameter X_W, default 6, column address width; Y_W, default 5, row address width.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  single-cycle request to begin a frame.
REQ-009 pix_valid  input  1  pix_data holds a valid pixel.
REQ-010 pix_data  input  PIX_W  pixel, raster order, row-major.
REQ-011 pix_ready  output  1  block accepts a pixel this cycle.
REQ-012 ii_we  output  1  integral-cache write enable.
REQ-013 ii_waddrX  output  X_W  integral-cache write column.
REQ-014 ii_waddrY  output  Y_W  integral-cache write row.
REQ-015 ii_wdata  output  SUM_W  integral value ii(x,y).
REQ-016 busy  output  1  high in ACTIVE and FLUSH.
REQ-017 frame_done  output  1  one-cycle pulse after the last write of a frame.

Function
REQ-018 States SHALL be IDLE, ACTIVE, FLUSH; IDLE->ACTIVE on start; ACTIVE->FLUSH on acceptance of pixel (IMG_W-1, IMG_H-1); FLUSH->IDLE after exactly one cycle.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 pix_ready SHALL equal 1 in ACTIVE and 0 otherwise; a pixel is accepted when pix_valid && pix_ready.
REQ-021 Column counter x and row counter y SHALL be cleared to 0 on IDLE->ACTIVE; x increments per accepted pixel, wraps IMG_W-1 -> 0 and increments y on wrap.
REQ-022 Row accumulator rowsum SHALL be (x==0 ? pix : rowsum + pix) for each accepted pixel.
REQ-023 Internal line buffer prev[0..IMG_W-1] (SUM_W each) SHALL hold the previous row's integral values; above = (y==0) ? 0 : prev[x], read combinationally then written with the new ii in the same cycle.
REQ-024 ii(x,y) = rowsum_new + above, arithmetic modulo 2^SUM_W, no saturation.
REQ-025 Latency: pixel accepted at cycle N -> ii_we=1 with ii_waddrX=x, ii_waddrY=y, ii_wdata=ii(x,y) at cycle N+1; all write outputs registered.
REQ-026 ii_we SHALL be 0 in any cycle not following an acceptance; ii_waddrX/Y/wdata hold last values when ii_we=0.
REQ-027 Gaps in pix_valid SHALL stall counters, rowsum and line buffer without changing results.
REQ-028 frame_done SHALL pulse in the cycle after FLUSH's write (i.e. the cycle the state returns to IDLE), exactly once per frame.
REQ-029 start asserted in the same cycle as frame_done SHALL begin a new frame (state is IDLE then).
REQ-030 The line buffer SHALL need no clearing between frames; the y==0 rule supplies zero.

Reset
REQ-031 On rst_n=0, immediately: state=IDLE, x=0, y=0, rowsum=0, pix_ready=0, ii_we=0, ii_waddrX=0, ii_waddrY=0, ii_wdata=0, busy=0, frame_done=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further writes and no frame_done; next frame requires start.
REQ-033 Line buffer contents are not reset.

Verification
REQ-034 IMG_W=4, IMG_H=3, all pixels 1, pix_valid held high -> 12 writes, ii(x,y)=(x+1)(y+1), last write (3,2)=12, frame_done one cycle later.
REQ-035 Same frame with pix_valid toggling 1,0,1,0 -> identical write sequence and values, ii_we only in cycles after acceptance.
REQ-036 All pixels 255 at default parameters -> final ii(31,23)=195840, no overflow.
REQ-037 Assert rst_n=0 after 5 pixels of a frame -> all outputs 0 at once, no frame_done; new start yields correct frame with row 0 using above=0.
REQ-038 Pulse start during ACTIVE and again on the frame_done cycle -> first ignored, second starts a new frame with x=y=0.
REQ-039 Ramp image pix=x+4y (4x3) -> each write matches software integral image reference.
